// File: rtl/synth_pkg.sv
// Shared types for the synth controller blocks.
package synth_pkg;

  // voice_alloc sequencing: wait for a command, walk all voices, commit result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2
  } voice_alloc_state_t;

  // A latched note command. on = 0 means note-off (including note-on with vel 0).
  typedef struct packed {
    logic       on;
    logic [7:0] key;
    logic [7:0] vel;
  } note_cmd_t;

endpackage

// File: rtl/utils.sv
// Generic helper functions shared across the synth codebase.
package utils;

  // Ceiling log2, never less than 1 so a single-entry table still gets an index bit.
  function automatic int clogb2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/voice_key_table.sv
// Per-voice key registers and gate bits for voice_alloc.
// Offers a single indexed read/compare (driven by the scan index) and
// set/clear ports used when a command is committed. clr_all wins over both.
module voice_key_table #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [V_WIDTH-1:0] rd_idx,
  input  logic [7:0]         rd_key,
  output logic               rd_on,
  output logic               rd_match,
  input  logic               wr_en,
  input  logic [V_WIDTH-1:0] wr_idx,
  input  logic [7:0]         wr_key,
  input  logic               clr_en,
  input  logic [V_WIDTH-1:0] clr_idx,
  input  logic               clr_all,
  output logic [VOICES-1:0]  keys_on
);

  logic [7:0] key_tab [VOICES];

  // A key entry is only meaningful while its gate is set; stale keys stay behind.
  assign rd_on    = keys_on[rd_idx];
  assign rd_match = keys_on[rd_idx] && (key_tab[rd_idx] == rd_key);

  // Gate and key storage: global release first, then the single commit write/clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_on <= '0;
      for (int v = 0; v < VOICES; v++) key_tab[v] <= 8'd0;
    end else if (clr_all) begin
      keys_on <= '0;
    end else begin
      if (wr_en) begin
        keys_on[wr_idx] <= 1'b1;
        key_tab[wr_idx] <= wr_key;
      end
      if (clr_en) keys_on[clr_idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Note-event allocator: maps MIDI note-on/off commands onto synth voices.
// A command is accepted in IDLE, SCAN walks every voice once (one per cycle)
// looking for a voice already holding the key and for the first idle voice,
// and ISSUE commits the result and registers all outputs.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
// (and all_off is low); cmd_ready is registered, high exactly in IDLE, and
// never looks at cmd_valid.
// Build option: define VOICE_STEAL_EN to steal voices round-robin when none is
// free; otherwise such note-ons are dropped and flagged on cmd_dropped.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = utils::clogb2(VOICES)
) (
  input  logic               CLOCK_50,
  input  logic               reset_reg_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_note_on,
  input  logic [7:0]         cmd_key,
  input  logic [7:0]         cmd_vel,
  input  logic               all_off,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic               voice_stolen,
  output logic               cmd_dropped,
  output voice_alloc_state_t dbg_state
);

  localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

  voice_alloc_state_t state;
  note_cmd_t          cmd;
  logic [V_WIDTH-1:0] scan_idx;
  logic               match_found;
  logic [V_WIDTH-1:0] match_idx;
  logic               free_found;
  logic [V_WIDTH-1:0] free_idx;
  logic               miss_q;

  logic               rd_on;
  logic               rd_match;
  logic               issue;
  logic               steal_ok;
  logic [V_WIDTH-1:0] steal_idx;
  logic               tbl_wr_en;
  logic [V_WIDTH-1:0] tbl_wr_idx;
  logic               tbl_clr_en;

  assign dbg_state = state;
  assign issue     = (state == ISSUE) && !all_off;

`ifdef VOICE_STEAL_EN
  logic [V_WIDTH-1:0] steal_ptr;

  assign steal_ok     = 1'b1;
  assign steal_idx    = steal_ptr;
  assign voice_stolen = miss_q;
  assign cmd_dropped  = 1'b0;

  // Round-robin victim pointer, advanced only when a note-on actually steals.
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      steal_ptr <= '0;
    end else if (issue && cmd.on && !match_found && !free_found) begin
      steal_ptr <= (steal_ptr == LAST_IDX) ? '0 : steal_ptr + 1'b1;
    end
  end
`else
  assign steal_ok     = 1'b0;
  assign steal_idx    = '0;
  assign voice_stolen = 1'b0;
  assign cmd_dropped  = miss_q;
`endif

  // Commit target: retrigger a matching voice, else the first idle one, else the victim.
  assign tbl_wr_idx = match_found ? match_idx : (free_found ? free_idx : steal_idx);
  assign tbl_wr_en  = issue && cmd.on && (match_found || free_found || steal_ok);
  assign tbl_clr_en = issue && !cmd.on && match_found;

  voice_key_table #(
    .VOICES  (VOICES),
    .V_WIDTH (V_WIDTH)
  ) u_table (
    .clk      (CLOCK_50),
    .rst_n    (reset_reg_N),
    .rd_idx   (scan_idx),
    .rd_key   (cmd.key),
    .rd_on    (rd_on),
    .rd_match (rd_match),
    .wr_en    (tbl_wr_en),
    .wr_idx   (tbl_wr_idx),
    .wr_key   (cmd.key),
    .clr_en   (tbl_clr_en),
    .clr_idx  (match_idx),
    .clr_all  (all_off),
    .keys_on  (keys_on)
  );

  // Sequencer, command latch, scan results and all registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state       <= IDLE;
      cmd         <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      cmd_ready   <= 1'b1;
      note_on     <= 1'b0;
      miss_q      <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= 8'd0;
      cur_vel_on  <= 8'd0;
      cur_vel_off <= 8'd0;
    end else begin
      note_on <= 1'b0;
      miss_q  <= 1'b0;
      if (all_off) begin
        // Global release: any in-flight command is discarded silently.
        state     <= IDLE;
        cmd_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              cmd.on      <= cmd_note_on && (cmd_vel != 8'd0);
              cmd.key     <= cmd_key;
              cmd.vel     <= cmd_vel;
              scan_idx    <= '0;
              match_found <= 1'b0;
              free_found  <= 1'b0;
              cmd_ready   <= 1'b0;
              state       <= SCAN;
            end
          end
          SCAN: begin
            if (!match_found && rd_match) begin
              match_found <= 1'b1;
              match_idx   <= scan_idx;
            end
            if (!free_found && voice_free[scan_idx] && !rd_on) begin
              free_found <= 1'b1;
              free_idx   <= scan_idx;
            end
            if (scan_idx == LAST_IDX) state <= ISSUE;
            else scan_idx <= scan_idx + 1'b1;
          end
          ISSUE: begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            if (cmd.on) begin
              if (match_found || free_found || steal_ok) begin
                note_on     <= 1'b1;
                cur_key_adr <= tbl_wr_idx;
                cur_key_val <= cmd.key;
                cur_vel_on  <= cmd.vel;
              end
              if (!match_found && !free_found) miss_q <= 1'b1;
            end else if (match_found) begin
              cur_key_adr <= match_idx;
              cur_key_val <= cmd.key;
              cur_vel_off <= cmd.vel;
            end
          end
          default: begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
